waymask_applier: RTL and testbench

- Consumes the suggested way-partition mask produced by the way-partition suggestion logic and applies it to the shared cache, acting as the enforcing end of the suggestion interface.
- Filters transient suggestions with a stability window. Growing a partition is applied directly. Shrinking a partition is applied safely: allocation into revoked ways stops first, then every (set, revoked way) line is flushed through a valid/ready request port, then the new mask is committed.
- Sits between the suggestion block and the cache replacement/allocation logic.

---
 rtl/waymask_applier.sv | 200 ++++++++++++++++++++
 tb/tb_waymask_applier.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/waymask_applier.sv
// waymask_applier
//   Enforcing end of the way-partition suggestion interface. Filters the
//   suggested allocation mask through a stability window, then applies it.
//   Growth is applied directly. A shrink first removes the revoked ways from
//   the active mask, then flushes every (set, revoked way) line through a
//   valid/ready port, and finally commits the new mask.
//
//   Ports:
//     clk_in, reset_n_in        clock, asynchronous active-low reset
//     enable_in                 allow new suggestions to be accepted
//     suggested_waymask_in      suggested mask (bit i = way i allowed)
//     active_waymask_out        allocation mask for the replacement logic
//     flush_valid_out/ready_in  flush request handshake
//     flush_set_out/way_out     flush payload (set index, one-hot way)
//     busy_out                  high while flushing or committing
//     update_count_out          committed updates, wraps at 16 bits
//
//   Optional: define WAYMASK_APPLIER_TRACE_EN to print commit and
//   flush-entry events through $display (simulation only).
//
//   state  | meaning
//   IDLE   | filter suggestions, wait for a stable differing mask
//   FLUSH  | issue one flush request per (set, revoked way)
//   COMMIT | load the new mask, bump the update counter
module waymask_applier #(
  parameter int CACHE_ASSOCIATIVITY = 16,
  parameter int SET_INDEX_WIDTH     = 10,
  parameter int STABLE_CYCLES       = 4
) (
  input  logic                           clk_in,
  input  logic                           reset_n_in,
  input  logic                           enable_in,
  input  logic [CACHE_ASSOCIATIVITY-1:0] suggested_waymask_in,
  output logic [CACHE_ASSOCIATIVITY-1:0] active_waymask_out,
  output logic                           flush_valid_out,
  input  logic                           flush_ready_in,
  output logic [SET_INDEX_WIDTH-1:0]     flush_set_out,
  output logic [CACHE_ASSOCIATIVITY-1:0] flush_way_out,
  output logic                           busy_out,
  output logic [15:0]                    update_count_out
);

  localparam int W  = CACHE_ASSOCIATIVITY;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]              STABLE_TC = CW'(STABLE_CYCLES);
  localparam logic [SET_INDEX_WIDTH-1:0] LAST_SET  = '1;
  localparam logic [W-1:0]               ONE       = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [W-1:0]               active_q, active_d;
  logic [W-1:0]               cand_q, cand_d;
  logic [W-1:0]               target_q, target_d;
  logic [W-1:0]               revoked_q, revoked_d;
  logic [W-1:0]               remain_q, remain_d;
  logic [SET_INDEX_WIDTH-1:0] set_q, set_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [15:0]                count_q, count_d;

  logic [W-1:0]  sanitized;
  logic [W-1:0]  revoked_new;
  logic [W-1:0]  lowbit;
  logic [W-1:0]  remain_nx;
  logic          qualify;
  logic [CW-1:0] run;

  // An empty partition is never allowed; fall back to way 0.
  assign sanitized   = (suggested_waymask_in == '0) ? ONE : suggested_waymask_in;
  assign revoked_new = active_q & ~sanitized;
  // Isolate the lowest set bit of the ways still to flush in this set.
  assign lowbit      = remain_q & (~remain_q + ONE);
  assign remain_nx   = remain_q & ~lowbit;
  assign qualify     = enable_in && (sanitized != active_q);

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    cand_d    = sanitized;
    target_d  = target_q;
    revoked_d = revoked_q;
    remain_d  = remain_q;
    set_d     = set_q;
    cnt_d     = cnt_q;
    count_d   = count_q;
    run       = '0;

    case (state_q)
      IDLE: begin
        // cnt_q holds the number of consecutive qualifying samples of
        // cand_q; a fresh value restarts the run at one sample.
        if (!qualify) begin
          cnt_d = '0;
        end else begin
          if ((sanitized == cand_q) && (cnt_q != '0)) begin
            run = (cnt_q == STABLE_TC) ? cnt_q : cnt_q + 1'b1;
          end else begin
            run = {{(CW-1){1'b0}}, 1'b1};
          end
          if (run == STABLE_TC) begin
            cnt_d    = '0;
            target_d = sanitized;
            if (revoked_new == '0) begin
              state_d = COMMIT;
            end else begin
              // Stop allocating into revoked ways before flushing them.
              active_d  = active_q & sanitized;
              revoked_d = revoked_new;
              remain_d  = revoked_new;
              set_d     = '0;
              state_d   = FLUSH;
            end
          end else begin
            cnt_d = run;
          end
        end
      end

      FLUSH: begin
        if (flush_ready_in) begin
          if (remain_nx == '0) begin
            if (set_q == LAST_SET) begin
              remain_d = '0;
              state_d  = COMMIT;
            end else begin
              set_d    = set_q + 1'b1;
              remain_d = revoked_q;
            end
          end else begin
            remain_d = remain_nx;
          end
        end
      end

      COMMIT: begin
        active_d = target_q;
        count_d  = count_q + 16'd1;
        cnt_d    = '0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= IDLE;
      active_q  <= '1;
      cand_q    <= '1;
      target_q  <= '1;
      revoked_q <= '0;
      remain_q  <= '0;
      set_q     <= '0;
      cnt_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      cand_q    <= cand_d;
      target_q  <= target_d;
      revoked_q <= revoked_d;
      remain_q  <= remain_d;
      set_q     <= set_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
    end
  end

  // Payload is gated by state so a reset mid-flush drops the request
  // immediately and idle outputs read as zero.
  assign flush_valid_out    = (state_q == FLUSH);
  assign flush_set_out      = (state_q == FLUSH) ? set_q : '0;
  assign flush_way_out      = (state_q == FLUSH) ? lowbit : '0;
  assign busy_out           = (state_q != IDLE);
  assign active_waymask_out = active_q;
  assign update_count_out   = count_q;

`ifdef WAYMASK_APPLIER_TRACE_EN
  always_ff @(posedge clk_in) begin
    if (reset_n_in) begin
      if (state_q == COMMIT) begin
        $display("waymask commit old=%h new=%h count=%0d",
                 active_q, target_q, count_q + 16'd1);
      end
      if ((state_q == IDLE) && (state_d == FLUSH)) begin
        $display("waymask flush revoked=%h", revoked_d);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_waymask_applier.sv
`timescale 1ns/1ps
module tb_waymask_applier;
  localparam int W  = 16;
  localparam int SW = 2;
  localparam int NS = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          rdy = 1'b0;
  logic [W-1:0]  sugg = '0;
  logic [W-1:0]  active;
  logic          fvalid;
  logic [SW-1:0] fset;
  logic [W-1:0]  fway;
  logic          busy;
  logic [15:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [SW-1:0] set;
    logic [W-1:0]  way;
  } hs_t;

  hs_t exp_q[$];
  hs_t got_q[$];

  logic [W-1:0] ref_active;
  logic [15:0]  ref_count;

  waymask_applier #(
    .CACHE_ASSOCIATIVITY(W),
    .SET_INDEX_WIDTH(SW),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk_in(clk),
    .reset_n_in(rst_n),
    .enable_in(en),
    .suggested_waymask_in(sugg),
    .active_waymask_out(active),
    .flush_valid_out(fvalid),
    .flush_ready_in(rdy),
    .flush_set_out(fset),
    .flush_way_out(fway),
    .busy_out(busy),
    .update_count_out(count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected flush order: set-major, ways ascending within each set.
  function automatic void build_exp(input logic [W-1:0] revoked);
    logic [W-1:0] one;
    hs_t h;
    one = 1;
    exp_q.delete();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < W; w++) begin
        if (revoked[w]) begin
          h.set = SW'(s);
          h.way = one << w;
          exp_q.push_back(h);
        end
      end
    end
  endfunction

  function automatic logic [W-1:0] lowest_bit(input logic [W-1:0] m);
    logic [W-1:0] one;
    one = 1;
    for (int w = 0; w < W; w++) begin
      if (m[w]) return one << w;
    end
    return '0;
  endfunction

  // Handshake recorder and payload-hold monitor.
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [SW-1:0] ps = '0;
  logic [W-1:0]  pw = '0;
  always @(negedge clk) begin
    if (rst_n && fvalid) begin
      chk("flush_way_onehot", 32'($onehot(fway)), 32'd1);
      if (pv && !pr) begin
        chk("payload_hold_set", 32'(fset), 32'(ps));
        chk("payload_hold_way", 32'(fway), 32'(pw));
      end
      if (rdy) got_q.push_back(hs_t'({fset, fway}));
    end
    pv = rst_n && fvalid;
    pr = rdy;
    ps = fset;
    pw = fway;
  end

  task automatic do_update(input logic [W-1:0] sv, input bit rnd,
                           input bit use_mid, input logic [W-1:0] mid);
    logic [W-1:0] tgt;
    logic [W-1:0] rev;
    int cyc;
    tgt = (sv == '0) ? 16'h0001 : sv;
    rev = ref_active & ~tgt;
    build_exp(rev);
    got_q.delete();
    rdy  = 1'b1;
    sugg = sv;
    for (int e = 1; e < SC; e++) begin
      @(posedge clk); #1;
      chk("window_busy", 32'(busy), 32'd0);
      chk("window_active", 32'(active), 32'(ref_active));
    end
    @(posedge clk); #1;
    chk("leave_idle_busy", 32'(busy), 32'd1);
    if (rev == '0) begin
      chk("grow_hold", 32'(active), 32'(ref_active));
      chk("grow_no_flush", 32'(fvalid), 32'd0);
      @(posedge clk); #1;
      chk("grow_active", 32'(active), 32'(tgt));
    end else begin
      chk("shrink_early_mask", 32'(active), 32'(ref_active & tgt));
      chk("flush_valid_entry", 32'(fvalid), 32'd1);
      chk("flush_set_entry", 32'(fset), 32'd0);
      chk("flush_way_entry", 32'(fway), 32'(lowest_bit(rev)));
    end
    cyc = 0;
    while (busy && cyc < 3000) begin
      if (rnd) rdy = 1'($urandom_range(0, 1));
      if (use_mid && cyc == 2) sugg = mid;
      @(posedge clk); #1;
      cyc++;
    end
    sugg = sv;
    rdy  = 1'b1;
    ref_active = tgt;
    ref_count  = ref_count + 16'd1;
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_active", 32'(active), 32'(ref_active));
    chk("done_count", 32'(count), 32'(ref_count));
    chk("hs_total", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk("hs_order", 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    logic [W-1:0] m;
    int cyc;

    rst_n = 1'b0;
    en    = 1'b1;
    rdy   = 1'b1;
    sugg  = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_active", 32'(active), 32'h0000FFFF);
    chk("rst_valid", 32'(fvalid), 32'd0);
    chk("rst_set", 32'(fset), 32'd0);
    chk("rst_way", 32'(fway), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ref_active = 16'hFFFF;
    ref_count  = 16'd0;

    // Shrink to the low byte: 8 ways x 4 sets.
    do_update(16'h00FF, 1'b0, 1'b0, '0);
    // Pure growth, no flush.
    do_update(16'h0FFF, 1'b0, 1'b0, '0);

    // Toggling suggestion never stabilises.
    for (int k = 0; k < 5; k++) begin
      sugg = 16'h00FF;
      repeat (2) begin
        @(posedge clk); #1;
        chk("toggle_busy", 32'(busy), 32'd0);
        chk("toggle_active", 32'(active), 32'(ref_active));
      end
      sugg = 16'hFFFF;
      repeat (2) begin
        @(posedge clk); #1;
        chk("toggle_busy", 32'(busy), 32'd0);
        chk("toggle_active", 32'(active), 32'(ref_active));
      end
    end
    sugg = ref_active;

    // Enable low blocks acceptance.
    en   = 1'b0;
    sugg = 16'h0F0F;
    repeat (8) begin
      @(posedge clk); #1;
      chk("disabled_busy", 32'(busy), 32'd0);
      chk("disabled_active", 32'(active), 32'(ref_active));
    end
    sugg = ref_active;
    @(posedge clk); #1;
    en = 1'b1;

    // Back-pressured flush with a mid-flush suggestion that must be ignored.
    do_update(16'h00FF, 1'b1, 1'b1, 16'h000F);

    // Random masks with random back-pressure.
    for (int k = 0; k < 3; k++) begin
      do begin
        m = W'($urandom);
      end while (((m == '0) ? 16'h0001 : m) == ref_active);
      do_update(m, 1'b1, 1'b0, '0);
    end

    // All-zero suggestion collapses to way 0.
    if (ref_active != 16'hFFFF) do_update(16'hFFFF, 1'b0, 1'b0, '0);
    do_update(16'h0000, 1'b1, 1'b0, '0);
    chk("zero_final_active", 32'(active), 32'h00000001);

    // Reset in the middle of a flush.
    do_update(16'hFFFF, 1'b0, 1'b0, '0);
    got_q.delete();
    rdy  = 1'b1;
    sugg = 16'h00FF;
    cyc  = 0;
    while (got_q.size() < 5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("pre_reset_hs", 32'(got_q.size()), 32'd5);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_valid_drop", 32'(fvalid), 32'd0);
    chk("async_way_drop", 32'(fway), 32'd0);
    chk("async_active", 32'(active), 32'h0000FFFF);
    chk("async_count", 32'(count), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    ref_active = 16'hFFFF;
    ref_count  = 16'd0;
    sugg = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_idle", 32'(busy), 32'd0);
    chk("post_reset_active", 32'(active), 32'(ref_active));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
